// File: rtl/pwm_ramp_ctrl_if.sv
// Host ramp-request channel for pwm_ramp_ctrl.
// Handshake: a request transfers on a rising clk edge where tgt_valid && tgt_ready;
// the master holds tgt_duty stable while tgt_valid is high, and tgt_ready never waits on tgt_valid.
interface pwm_ramp_ctrl_if;
   logic       tgt_valid;
   logic [3:0] tgt_duty;
   logic       tgt_ready;

   modport master (output tgt_valid, output tgt_duty, input  tgt_ready);
   modport slave  (input  tgt_valid, input  tgt_duty, output tgt_ready);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Button/host driven duty-step controller: debounced buttons and host ramp requests
// are turned into spaced inc/dec pulses for a PWM generator, with a local duty shadow.
module pwm_ramp_ctrl #(
   parameter int DEB_CYCLES = 4,
   parameter int STEP_GAP   = 8,
   parameter int DUTY_MAX   = 10,
   parameter int DUTY_INIT  = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_btn_inc,
   input  logic           i_btn_dec,
   pwm_ramp_ctrl_if.slave tgt_if,
   output logic           o_inc_pulse,
   output logic           o_dec_pulse,
   output logic [3:0]     o_duty,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_sat,
   output logic [1:0]     o_state
);

   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int GAP_W = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(STEP_GAP - 1);
   localparam logic [3:0]       DUTY_MAX_L = 4'(DUTY_MAX);
   localparam logic [3:0]       DUTY_INIT_L = 4'(DUTY_INIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // Bit 0 carries the increase button, bit 1 the decrease button.
   logic [1:0]       w_btn;
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_deb;
   logic [1:0]       r_deb_q;
   logic [DEB_W-1:0] r_deb_cnt [2];
   logic [1:0]       w_ev;

   assign w_btn = {i_btn_dec, i_btn_inc};
   assign w_ev  = r_deb & ~r_deb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_deb_q <= '0;
         for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_btn;
         r_sync2 <= r_sync1;
         r_deb_q <= r_deb;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] != r_deb[i]) begin
               if (r_deb_cnt[i] == DEB_LAST) begin
                  r_deb[i]     <= r_sync2[i];
                  r_deb_cnt[i] <= '0;
               end else begin
                  r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
               end
            end else begin
               r_deb_cnt[i] <= '0;
            end
         end
      end
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_ramp;
   logic             w_ramp_nxt;
   logic [3:0]       r_target;
   logic [3:0]       w_target_nxt;
   logic [3:0]       r_duty;
   logic [3:0]       w_duty_nxt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [GAP_W-1:0] w_gap_nxt;
   logic             r_inc;
   logic             w_inc_nxt;
   logic             r_dec;
   logic             w_dec_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_sat;
   logic             w_sat_nxt;
   logic             r_ready;
   logic             r_busy;
   logic [3:0]       w_tgt_clip;

   always_comb begin
      w_state_nxt  = r_state;
      w_ramp_nxt   = r_ramp;
      w_target_nxt = r_target;
      w_duty_nxt   = r_duty;
      w_gap_nxt    = r_gap_cnt;
      w_inc_nxt    = 1'b0;
      w_dec_nxt    = 1'b0;
      w_done_nxt   = 1'b0;
      w_sat_nxt    = 1'b0;
      w_tgt_clip   = (tgt_if.tgt_duty > DUTY_MAX_L) ? DUTY_MAX_L : tgt_if.tgt_duty;

      unique case (r_state)
         S_IDLE: begin
            // A host request outranks any button event arriving in the same cycle.
            if (tgt_if.tgt_valid && r_ready) begin
               w_target_nxt = w_tgt_clip;
               if (w_tgt_clip == r_duty) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_ramp_nxt  = 1'b1;
                  w_state_nxt = S_PULSE;
                  if (w_tgt_clip > r_duty) begin
                     w_inc_nxt  = 1'b1;
                     w_duty_nxt = r_duty + 4'd1;
                  end else begin
                     w_dec_nxt  = 1'b1;
                     w_duty_nxt = r_duty - 4'd1;
                  end
               end
            end else if (w_ev[0] && !w_ev[1]) begin
               if (r_duty < DUTY_MAX_L) begin
                  w_state_nxt = S_PULSE;
                  w_inc_nxt   = 1'b1;
                  w_duty_nxt  = r_duty + 4'd1;
               end else begin
                  w_sat_nxt = 1'b1;
               end
            end else if (w_ev[1] && !w_ev[0]) begin
               if (r_duty != 4'd0) begin
                  w_state_nxt = S_PULSE;
                  w_dec_nxt   = 1'b1;
                  w_duty_nxt  = r_duty - 4'd1;
               end else begin
                  w_sat_nxt = 1'b1;
               end
            end
         end
         S_PULSE: begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
         end
         S_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               if (r_ramp && (r_duty != r_target)) begin
                  w_state_nxt = S_PULSE;
                  if (r_target > r_duty) begin
                     w_inc_nxt  = 1'b1;
                     w_duty_nxt = r_duty + 4'd1;
                  end else begin
                     w_dec_nxt  = 1'b1;
                     w_duty_nxt = r_duty - 4'd1;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = r_ramp;
                  w_ramp_nxt  = 1'b0;
               end
            end else begin
               w_gap_nxt = r_gap_cnt + GAP_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ramp    <= 1'b0;
         r_target  <= DUTY_INIT_L;
         r_duty    <= DUTY_INIT_L;
         r_gap_cnt <= '0;
         r_inc     <= 1'b0;
         r_dec     <= 1'b0;
         r_done    <= 1'b0;
         r_sat     <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ramp    <= w_ramp_nxt;
         r_target  <= w_target_nxt;
         r_duty    <= w_duty_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_inc     <= w_inc_nxt;
         r_dec     <= w_dec_nxt;
         r_done    <= w_done_nxt;
         r_sat     <= w_sat_nxt;
         r_ready   <= (w_state_nxt == S_IDLE);
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign tgt_if.tgt_ready = r_ready;
   assign o_inc_pulse      = r_inc;
   assign o_dec_pulse      = r_dec;
   assign o_duty           = r_duty;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_sat            = r_sat;
   assign o_state          = r_state;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: stimulus pushes time-stamped expected events,
// a negedge monitor pops and compares every inc/dec/done/sat output it sees.
module tb_pwm_ramp_ctrl;

   localparam int EW          = 22;
   localparam int BTN_LAT     = 7;
   localparam int STEP_PERIOD = 9;
   localparam logic [1:0] K_INC  = 2'd0;
   localparam logic [1:0] K_DEC  = 2'd1;
   localparam logic [1:0] K_DONE = 2'd2;
   localparam logic [1:0] K_SAT  = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic       inc_pulse;
   logic       dec_pulse;
   logic [3:0] duty;
   logic       busy;
   logic       done;
   logic       sat;
   logic [1:0] state;

   pwm_ramp_ctrl_if tgt_if ();

   pwm_ramp_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_btn_inc   (btn_inc),
      .i_btn_dec   (btn_dec),
      .tgt_if      (tgt_if),
      .o_inc_pulse (inc_pulse),
      .o_dec_pulse (dec_pulse),
      .o_duty      (duty),
      .o_busy      (busy),
      .o_done      (done),
      .o_sat       (sat),
      .o_state     (state)
   );

   // Clock and cycle stamp: cyc equals the number of rising edges seen so far.
   int cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int            n_checks = 0;
   int            n_fails  = 0;
   int            busy_cnt = 0;
   logic [EW-1:0] exp_q [$];

   function automatic logic [EW-1:0] mk_ev(int c, logic [1:0] k, logic [3:0] d);
      return {16'(c), k, d};
   endfunction

   function automatic string kname(logic [1:0] k);
      case (k)
         K_INC:   return "inc";
         K_DEC:   return "dec";
         K_DONE:  return "done";
         default: return "sat";
      endcase
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   task automatic sb_pop(logic [1:0] k);
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      act = mk_ev(cyc, k, duty);
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fails++;
         $display("FAIL sb_unexpected: got cyc=%0d %s duty=%0d, expected no event",
                  cyc, kname(k), duty);
      end else begin
         exp = exp_q.pop_front();
         if (act != exp) begin
            n_fails++;
            $display("FAIL sb_event: got cyc=%0d %s duty=%0d, expected cyc=%0d %s duty=%0d",
                     act[21:6], kname(act[5:4]), act[3:0],
                     exp[21:6], kname(exp[5:4]), exp[3:0]);
         end
      end
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] stale;
      if (inc_pulse) sb_pop(K_INC);
      if (dec_pulse) sb_pop(K_DEC);
      if (done)      sb_pop(K_DONE);
      if (sat)       sb_pop(K_SAT);
      if (inc_pulse || dec_pulse) begin
         check("pulse_exclusive", int'(inc_pulse && dec_pulse), 0);
         check("duty_in_range", int'(duty <= 4'd10), 1);
      end
      while (exp_q.size() > 0 && exp_q[0][21:6] < 16'(cyc)) begin
         stale = exp_q.pop_front();
         n_checks++;
         n_fails++;
         $display("FAIL sb_missed: got nothing by cyc=%0d, expected cyc=%0d %s duty=%0d",
                  cyc, stale[21:6], kname(stale[5:4]), stale[3:0]);
      end
      if (busy) busy_cnt++;
   end

   // Driver tasks
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(int c, logic [1:0] k, logic [3:0] d);
      exp_q.push_back(mk_ev(c, k, d));
   endtask

   // Request issued after edge n is accepted at edge n+1, so step j lands at n+1+9j.
   task automatic push_ramp(int n, int from, int to);
      int steps;
      steps = (to > from) ? (to - from) : (from - to);
      for (int j = 0; j < steps; j++) begin
         if (to > from) push(n + 1 + STEP_PERIOD * j, K_INC, 4'(from + j + 1));
         else           push(n + 1 + STEP_PERIOD * j, K_DEC, 4'(from - j - 1));
      end
      push(n + 1 + STEP_PERIOD * steps, K_DONE, 4'(to));
   endtask

   task automatic ramp_req(logic [3:0] t);
      tgt_if.tgt_valid = 1'b1;
      tgt_if.tgt_duty  = t;
      tick(1);
      tgt_if.tgt_valid = 1'b0;
   endtask

   task automatic press(logic do_inc, logic do_dec, int hold, int rest);
      btn_inc = do_inc;
      btn_dec = do_dec;
      tick(hold);
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      tick(rest);
   endtask

   initial begin
      int n;
      int busy_base;
      int ready_hi;
      tgt_if.tgt_valid = 1'b0;
      tgt_if.tgt_duty  = 4'd0;
      tick(3);

      check("rst_ready", int'(tgt_if.tgt_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_duty", int'(duty), 5);
      check("rst_pulses", int'({inc_pulse, dec_pulse, done, sat}), 0);
      check("rst_state", int'(state), 0);
      rst_n = 1'b1;
      tick(3);
      check("post_rst_duty", int'(duty), 5);

      // Single button step 5 -> 6
      n = cyc;
      busy_base = busy_cnt;
      push(n + BTN_LAT, K_INC, 4'd6);
      press(1'b1, 1'b0, 20, 15);
      check("btn_busy_cycles", busy_cnt - busy_base, 9);
      check("btn_duty", int'(duty), 6);

      // Three-cycle glitch is filtered
      press(1'b1, 1'b0, 3, 20);
      check("glitch_duty", int'(duty), 6);

      // Ramp down to 5, then up to 9 with btn_dec pressed mid-ramp
      n = cyc;
      push_ramp(n, 6, 5);
      ramp_req(4'd5);
      tick(11);
      n = cyc;
      push_ramp(n, 5, 9);
      ramp_req(4'd9);
      ready_hi = 0;
      for (int i = 1; i <= 36; i++) begin
         if (tgt_if.tgt_ready) ready_hi++;
         if (i == 3)  btn_dec = 1'b1;
         if (i == 13) btn_dec = 1'b0;
         tick(1);
      end
      check("ramp_ready_low", ready_hi, 0);
      check("ramp_ready_back", int'(tgt_if.tgt_ready), 1);
      check("ramp9_duty", int'(duty), 9);
      tick(10);

      // Target equal to duty: immediate done
      n = cyc;
      push_ramp(n, 9, 9);
      ramp_req(4'd9);
      tick(5);

      // Down to 5, then an over-range request clipped to 10
      n = cyc;
      push_ramp(n, 9, 5);
      ramp_req(4'd5);
      tick(39);
      n = cyc;
      push_ramp(n, 5, 10);
      ramp_req(4'd15);
      tick(48);
      check("clip_duty", int'(duty), 10);

      // inc at the top saturates; both buttons together do nothing
      n = cyc;
      push(n + BTN_LAT, K_SAT, 4'd10);
      press(1'b1, 1'b0, 10, 15);
      press(1'b1, 1'b1, 10, 15);
      check("both_btn_duty", int'(duty), 10);
      n = cyc;
      push(n + BTN_LAT, K_DEC, 4'd9);
      press(1'b0, 1'b1, 10, 15);

      // Ramp to 0, then dec saturates at the bottom
      n = cyc;
      push_ramp(n, 9, 0);
      ramp_req(4'd0);
      tick(83);
      check("zero_duty", int'(duty), 0);
      n = cyc;
      push(n + BTN_LAT, K_SAT, 4'd0);
      press(1'b0, 1'b1, 10, 15);

      // Reset during the GAP after the step to 7
      n = cyc;
      for (int j = 0; j < 7; j++) push(n + 1 + STEP_PERIOD * j, K_INC, 4'(j + 1));
      ramp_req(4'd9);
      tick(57);
      check("pre_abort_duty", int'(duty), 7);
      rst_n = 1'b0;
      #1;
      check("abort_pulses", int'({inc_pulse, dec_pulse, done, sat}), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_duty", int'(duty), 5);
      check("abort_ready", int'(tgt_if.tgt_ready), 1);
      check("abort_state", int'(state), 0);
      tick(3);
      rst_n = 1'b1;
      tick(60);
      check("after_abort_duty", int'(duty), 5);
      check("after_abort_busy", int'(busy), 0);

      tick(2);
      check("sb_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: cycles a synchronized button level must hold before the debounced level changes (>=1).
REQ-002 Parameter STEP_GAP, default 8: idle cycles forced after every step pulse (>=1).
REQ-003 Parameter DUTY_MAX, default 10: maximum duty step count, each step = 10%.
REQ-004 Parameter DUTY_INIT, default 5: duty step count of the driven PWM generator after reset.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 btn_inc  in  1  raw asynchronous increase button.
REQ-008 btn_dec  in  1  raw asynchronous decrease button.
REQ-009 tgt_valid  in  1  host ramp request valid.
REQ-010 tgt_duty  in  4  requested duty step count.
REQ-011 tgt_ready  out  1  request accepted when tgt_valid & tgt_ready at a clock edge.
REQ-012 inc_pulse  out  1  one-cycle pulse to generator increase_duty.
REQ-013 dec_pulse  out  1  one-cycle pulse to generator decrease_duty.
REQ-014 duty  out  4  shadow of generator duty step count.
REQ-015 busy  out  1  high whenever FSM not in IDLE.
REQ-016 done  out  1  one-cycle pulse: accepted ramp reached target.
REQ-017 sat  out  1  one-cycle pulse: button step refused at 0 or DUTY_MAX.

Function
REQ-018 Each button SHALL pass a 2-flop synchronizer, then a debouncer: counter advances while synced level != debounced level, clears otherwise; debounced level flips when counter reaches DEB_CYCLES.
REQ-019 Button event = debounced rising edge; falling edges generate nothing.
REQ-020 FSM states SHALL be IDLE, PULSE, GAP; all outputs registered.
REQ-021 tgt_ready SHALL equal (state == IDLE); inc/dec event pulses held off while not IDLE are dropped, not queued.
REQ-022 On accept, target = min(tgt_duty, DUTY_MAX); if target == duty, done SHALL pulse next cycle, FSM stays IDLE.
REQ-023 On accept with target != duty, FSM SHALL enter PULSE with ramp mode set.
REQ-024 In PULSE exactly one of inc_pulse/dec_pulse SHALL be high for one cycle, direction toward target; duty updates by +/-1 in that same cycle.
REQ-025 After PULSE, FSM SHALL spend exactly STEP_GAP cycles in GAP, all pulses low; pulse spacing in a ramp = STEP_GAP+1 cycles.
REQ-026 At GAP end in ramp mode: duty != target -> PULSE; duty == target -> IDLE with done high one cycle, ramp mode cleared.
REQ-027 Button event in IDLE: inc with duty < DUTY_MAX or dec with duty > 0 -> single PULSE then GAP then IDLE, no done.
REQ-028 Button event at limit (inc at DUTY_MAX, dec at 0): no pulse, sat high one cycle, FSM stays IDLE.
REQ-029 Simultaneous inc and dec events: both dropped, no pulse, no sat.
REQ-030 Simultaneous tgt accept and button event in IDLE: ramp wins, button event dropped.
REQ-031 Latency: raw button rising, held stable, first sampled at edge k -> pulse high after edge k+DEB_CYCLES+2, i.e. DEB_CYCLES+3 edges counting k.
REQ-032 inc_pulse and dec_pulse SHALL never be high together; duty SHALL never leave 0..DUTY_MAX.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, ramp mode clear, duty = DUTY_INIT, synchronizers, debounced levels and counters 0, inc_pulse/dec_pulse/done/sat/busy 0; tgt_ready rises to 1 with state IDLE.
REQ-034 Reset mid-ramp SHALL abort without done; generator must be reset in the same window so duty shadow stays valid.
REQ-035 Release of rst_n SHALL be the only event; no pulse issued in first cycle after release.

Verification
REQ-036 Reset, btn_inc high 20 cycles (defaults) -> one inc_pulse 7 edges after first sample, duty 5->6, busy 9 cycles, no sat.
REQ-037 btn_inc glitch high 3 cycles -> no pulse, duty unchanged.
REQ-038 tgt_duty=9 from duty 5 -> four inc_pulses 9 cycles apart, duty 9, done one cycle after last GAP, tgt_ready low throughout.
REQ-039 tgt_duty=15 from duty 5 -> ramp to 10, five inc_pulses, done; then btn_inc event -> sat pulse, no inc_pulse.
REQ-040 btn_dec pressed during ramp, and both buttons pressed together in IDLE -> no extra pulses, duty follows ramp only.
REQ-041 rst_n low mid-ramp at duty 7 -> outputs 0 immediately, duty 5, no done after release.
